// File: rtl/interboard_receiver_pkg.sv
// Shared definitions for the Request/Ack inter-board link: word order, field bit positions,
// receiver FSM states and the word-to-field unpacking helper.
package interboard_receiver_pkg;

  localparam int WORD_W    = 6;
  localparam int NUM_WORDS = 4;

  localparam logic [1:0] W_HDR  = 2'd0;
  localparam logic [1:0] W_CARD = 2'd1;
  localparam logic [1:0] W_YSEL = 2'd2;
  localparam logic [1:0] W_X    = 2'd3;

  localparam int HDR_RST_BIT  = 5;
  localparam int HDR_DIR_BIT  = 4;
  localparam int HDR_TYPE_MSB = 3;
  localparam int YSEL_Y_MSB   = 5;
  localparam int YSEL_Y_LSB   = 3;
  localparam int YSEL_SEL_MSB = 2;
  localparam int X_MSB        = 4;

  typedef enum logic [1:0] {
    ST_IDLE_LOW  = 2'd0,
    ST_WAIT_REQ  = 2'd1,
    ST_WAIT_DROP = 2'd2,
    ST_DELIVER   = 2'd3
  } rx_state_e;

  typedef struct packed {
    logic       move_dir;
    logic [4:0] block_x;
    logic [2:0] block_y;
    logic [3:0] msg_type;
    logic [5:0] card;
    logic [2:0] sel_len;
  } rx_fields_t;

  function automatic rx_fields_t unpack_words(input logic [NUM_WORDS-1:0][WORD_W-1:0] w);
    rx_fields_t f;
    f.move_dir = w[W_HDR][HDR_DIR_BIT];
    f.msg_type = w[W_HDR][HDR_TYPE_MSB:0];
    f.card     = w[W_CARD];
    f.block_y  = w[W_YSEL][YSEL_Y_MSB:YSEL_Y_LSB];
    f.sel_len  = w[W_YSEL][YSEL_SEL_MSB:0];
    f.block_x  = w[W_X][X_MSB:0];
    return f;
  endfunction

endpackage

// File: rtl/interboard_receiver_sync_bit.sv
// Multi-stage synchroniser for a single asynchronous input bit.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_chain;

  // Reset to "high" so a line that is already high at reset release never looks like a fresh low.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_chain <= {STAGES{1'b1}};
    end else begin
      r_chain <= {r_chain[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/interboard_receiver.sv
// Inter-board link receiver: four-phase Request/Ack handshake, reassembles four 6-bit words
// into one game message and emits a one-cycle enable or remote-reset pulse.
module interboard_receiver #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Request,
  input  logic [5:0] interboard_data,
  output logic       Ack,
  output logic       interboard_rst,
  output logic       interboard_en,
  output logic       interboard_move_dir,
  output logic [4:0] interboard_block_x,
  output logic [2:0] interboard_block_y,
  output logic [3:0] interboard_msg_type,
  output logic [5:0] interboard_card,
  output logic [2:0] interboard_sel_len,
  output logic       rx_busy
);
  import interboard_receiver_pkg::*;

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  rx_state_e                              r_state, w_state_nxt;
  logic                                   r_ack, w_ack_nxt;
  logic                                   r_armed, w_armed_nxt;
  logic                                   r_busy, w_busy_nxt;
  logic [1:0]                             r_word_cnt, w_cnt_nxt;
  logic [NUM_WORDS-1:0][WORD_W-1:0]       r_shadow, w_shadow_nxt;
  rx_fields_t                             r_fields, w_fields_nxt;
  logic                                   r_en, w_en_nxt;
  logic                                   r_rstp, w_rstp_nxt;
  logic [TMO_W-1:0]                       r_tmo_cnt;
  logic                                   w_req_s;
  logic                                   w_timeout;
  logic                                   w_ack_fall;

  sync_bit #(.STAGES(SYNC_STAGES)) u_req_sync (
    .clk (clk),
    .rst (rst),
    .i_d (Request),
    .o_q (w_req_s)
  );

  assign w_timeout = r_busy && (r_tmo_cnt == TMO_W'(TIMEOUT - 1));

  // Next-state and next-output logic for the handshake FSM.
  always_comb begin
    w_state_nxt  = r_state;
    w_ack_nxt    = r_ack;
    w_armed_nxt  = r_armed;
    w_busy_nxt   = r_busy;
    w_cnt_nxt    = r_word_cnt;
    w_shadow_nxt = r_shadow;
    w_fields_nxt = r_fields;
    w_en_nxt     = 1'b0;
    w_rstp_nxt   = 1'b0;
    w_ack_fall   = 1'b0;
    if (w_timeout) begin
      // Abort lands in IDLE_LOW so a Request stuck high is not taken as a new word.
      w_state_nxt  = ST_IDLE_LOW;
      w_ack_nxt    = 1'b0;
      w_armed_nxt  = 1'b0;
      w_busy_nxt   = 1'b0;
      w_cnt_nxt    = 2'd0;
      w_shadow_nxt = '0;
    end else begin
      case (r_state)
        ST_IDLE_LOW: begin
          if (!w_req_s) begin
            w_armed_nxt = 1'b1;
            w_state_nxt = ST_WAIT_REQ;
          end else begin
            w_state_nxt = ST_IDLE_LOW;
          end
        end
        ST_WAIT_REQ: begin
          if (w_req_s && r_armed) begin
            w_shadow_nxt[r_word_cnt] = interboard_data;
            w_ack_nxt   = 1'b1;
            w_busy_nxt  = 1'b1;
            w_state_nxt = ST_WAIT_DROP;
          end else begin
            w_state_nxt = ST_WAIT_REQ;
          end
        end
        ST_WAIT_DROP: begin
          if (!w_req_s) begin
            w_ack_nxt  = 1'b0;
            w_ack_fall = 1'b1;
            if (r_word_cnt == W_X) begin
              w_state_nxt = ST_DELIVER;
            end else begin
              w_cnt_nxt   = r_word_cnt + 2'd1;
              w_state_nxt = ST_WAIT_REQ;
            end
          end else begin
            w_state_nxt = ST_WAIT_DROP;
          end
        end
        ST_DELIVER: begin
          if (r_shadow[W_HDR][HDR_RST_BIT]) begin
            w_rstp_nxt = 1'b1;
          end else begin
            w_en_nxt     = 1'b1;
            w_fields_nxt = unpack_words(r_shadow);
          end
          w_cnt_nxt   = 2'd0;
          w_busy_nxt  = 1'b0;
          w_state_nxt = ST_WAIT_REQ;
        end
        default: begin
          w_state_nxt = ST_IDLE_LOW;
          w_ack_nxt   = 1'b0;
          w_armed_nxt = 1'b0;
          w_busy_nxt  = 1'b0;
          w_cnt_nxt   = 2'd0;
        end
      endcase
    end
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE_LOW;
      r_ack      <= 1'b0;
      r_armed    <= 1'b0;
      r_busy     <= 1'b0;
      r_word_cnt <= 2'd0;
      r_shadow   <= '0;
      r_fields   <= '0;
      r_en       <= 1'b0;
      r_rstp     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ack      <= w_ack_nxt;
      r_armed    <= w_armed_nxt;
      r_busy     <= w_busy_nxt;
      r_word_cnt <= w_cnt_nxt;
      r_shadow   <= w_shadow_nxt;
      r_fields   <= w_fields_nxt;
      r_en       <= w_en_nxt;
      r_rstp     <= w_rstp_nxt;
    end
  end

  // Inter-word watchdog: runs while busy, restarts on every Ack fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tmo_cnt <= '0;
    end else if (!r_busy || w_ack_fall || w_timeout) begin
      r_tmo_cnt <= '0;
    end else begin
      r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
    end
  end

  assign Ack                 = r_ack;
  assign interboard_rst      = r_rstp;
  assign interboard_en       = r_en;
  assign interboard_move_dir = r_fields.move_dir;
  assign interboard_block_x  = r_fields.block_x;
  assign interboard_block_y  = r_fields.block_y;
  assign interboard_msg_type = r_fields.msg_type;
  assign interboard_card     = r_fields.card;
  assign interboard_sel_len  = r_fields.sel_len;
  assign rx_busy             = r_busy;

endmodule

// File: tb/tb_interboard_receiver.sv
// Randomised bench for interboard_receiver: a four-phase peer model drives messages and a
// behavioural model predicts pulses and decoded fields.
module tb_interboard_receiver;

  localparam int SYNC = 2;
  localparam int TMO  = 200;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       Request = 1'b0;
  logic [5:0] interboard_data = 6'd0;
  logic       Ack, interboard_rst, interboard_en, interboard_move_dir, rx_busy;
  logic [4:0] interboard_block_x;
  logic [2:0] interboard_block_y;
  logic [3:0] interboard_msg_type;
  logic [5:0] interboard_card;
  logic [2:0] interboard_sel_len;

  int n_total = 0;
  int n_bad   = 0;
  int en_cnt  = 0;
  int rp_cnt  = 0;
  int both_cnt = 0;
  int exp_en  = 0;
  int exp_rp  = 0;
  logic [21:0] exp_fields = 22'd0;

  interboard_receiver #(.SYNC_STAGES(SYNC), .TIMEOUT(TMO)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .Request             (Request),
    .interboard_data     (interboard_data),
    .Ack                 (Ack),
    .interboard_rst      (interboard_rst),
    .interboard_en       (interboard_en),
    .interboard_move_dir (interboard_move_dir),
    .interboard_block_x  (interboard_block_x),
    .interboard_block_y  (interboard_block_y),
    .interboard_msg_type (interboard_msg_type),
    .interboard_card     (interboard_card),
    .interboard_sel_len  (interboard_sel_len),
    .rx_busy             (rx_busy)
  );

  always #5 clk = ~clk;

  // Pulse monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (interboard_en) en_cnt <= en_cnt + 1;
      if (interboard_rst) rp_cnt <= rp_cnt + 1;
      if (interboard_en && interboard_rst) both_cnt <= both_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [21:0] model_fields(input int w0, input int w1, input int w2, input int w3);
    int dir, typ, card, y, sel, x;
    dir  = (w0 / 16) % 2;
    typ  = w0 % 16;
    card = w1;
    y    = w2 / 8;
    sel  = w2 % 8;
    x    = w3 % 32;
    return {1'(dir), 5'(x), 3'(y), 4'(typ), 6'(card), 3'(sel)};
  endfunction

  function automatic logic [21:0] fields_now();
    return {interboard_move_dir, interboard_block_x, interboard_block_y,
            interboard_msg_type, interboard_card, interboard_sel_len};
  endfunction

  function automatic logic [25:0] all_outs();
    return {Ack, interboard_rst, interboard_en, rx_busy, fields_now()};
  endfunction

  task automatic wait_ack(input logic level, output int lat);
    lat = 0;
    while (Ack !== level && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  // Peer side of one four-phase word transfer, with data scrambled while Ack is high.
  task automatic send_word(input logic [5:0] w, output bit ok);
    int lat;
    ok = 1'b0;
    interboard_data = w;
    Request = 1'b1;
    wait_ack(1'b1, lat);
    chk("ack_rise_lat", lat, SYNC + 1);
    if (Ack !== 1'b1) begin
      Request = 1'b0;
      return;
    end
    interboard_data = 6'($urandom);
    repeat ($urandom_range(0, 3)) tick();
    chk("ack_hold", Ack, 1'b1);
    Request = 1'b0;
    wait_ack(1'b0, lat);
    chk("ack_fall_lat", lat, SYNC + 1);
    ok = (Ack === 1'b0);
  endtask

  task automatic send_msg(input logic [5:0] w0, input logic [5:0] w1,
                          input logic [5:0] w2, input logic [5:0] w3);
    logic [5:0] ws [4];
    bit ok;
    bit flag;
    ws = '{w0, w1, w2, w3};
    for (int i = 0; i < 4; i++) begin
      send_word(ws[i], ok);
      if (!ok) return;
      if (i == 0) chk("busy_mid", rx_busy, 1'b1);
      if (i < 3) repeat ($urandom_range(0, 2)) tick();
    end
    flag = (int'(w0) >= 32);
    tick();
    chk("en_pulse", interboard_en, flag ? 1'b0 : 1'b1);
    chk("rst_pulse", interboard_rst, flag ? 1'b1 : 1'b0);
    if (flag) begin
      exp_rp++;
    end else begin
      exp_en++;
      exp_fields = model_fields(int'(w0), int'(w1), int'(w2), int'(w3));
    end
    tick();
    chk("fields", fields_now(), exp_fields);
    chk("busy_done", rx_busy, 1'b0);
    chk("en_count", en_cnt, exp_en);
    chk("rst_count", rp_cnt, exp_rp);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    bit ok;
    int lat;
    int ack_seen;
    logic [5:0] r0;

    // Reset values
    rst = 1'b1;
    repeat (3) tick();
    chk("reset_outs", all_outs(), 26'd0);
    rst = 1'b0;
    repeat (3) tick();

    // Directed messages: plain, header with reset flag, and reset-flag-only header
    send_msg(6'h05, 6'h2A, 6'h3B, 6'h13);
    send_msg(6'h25, 6'h11, 6'h07, 6'h33);
    send_msg(6'h20, 6'h3F, 6'h3F, 6'h3F);

    // Request held high through reset release is never accepted
    rst = 1'b1;
    Request = 1'b1;
    interboard_data = 6'h15;
    repeat (3) tick();
    rst = 1'b0;
    exp_fields = 22'd0;
    ack_seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (Ack) ack_seen++;
    end
    chk("stale_req_ack", ack_seen, 0);
    Request = 1'b0;
    repeat (4) tick();
    send_msg(6'h1C, 6'h05, 6'h29, 6'h3E);

    // Timeout between words
    send_word(6'h0A, ok);
    send_word(6'h01, ok);
    repeat (TMO + 5) tick();
    chk("tmo_busy", rx_busy, 1'b0);
    chk("tmo_ack", Ack, 1'b0);
    chk("tmo_en_count", en_cnt, exp_en);
    chk("tmo_rst_count", rp_cnt, exp_rp);
    send_msg(6'h13, 6'h22, 6'h1A, 6'h0F);

    // Timeout with Request stuck high: word is not re-accepted
    interboard_data = 6'h07;
    Request = 1'b1;
    wait_ack(1'b1, lat);
    chk("stuck_ack_rise", Ack, 1'b1);
    repeat (TMO + 5) tick();
    chk("stuck_tmo_ack", Ack, 1'b0);
    chk("stuck_tmo_busy", rx_busy, 1'b0);
    ack_seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (Ack) ack_seen++;
    end
    chk("stuck_no_reaccept", ack_seen, 0);
    Request = 1'b0;
    repeat (4) tick();
    send_msg(6'h0E, 6'h30, 6'h12, 6'h21);

    // Reset while Ack is high during word 2
    send_word(6'h09, ok);
    send_word(6'h14, ok);
    interboard_data = 6'h2D;
    Request = 1'b1;
    wait_ack(1'b1, lat);
    chk("mid_ack_rise", Ack, 1'b1);
    rst = 1'b1;
    tick();
    chk("mid_rst_outs", all_outs(), 26'd0);
    rst = 1'b0;
    exp_fields = 22'd0;
    Request = 1'b0;
    repeat (5) tick();
    send_msg(6'h1F, 6'h01, 6'h3C, 6'h1D);

    // Random traffic
    for (int m = 0; m < 20; m++) begin
      r0 = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) r0 = r0 & 6'h1F;
      send_msg(r0, 6'($urandom), 6'($urandom), 6'($urandom));
      repeat ($urandom_range(0, 4)) tick();
    end

    chk("en_rst_overlap", both_cnt, 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
